// File: rtl/fetch_queue_pkg.sv
// Shared front-end constants: PC width, decoded-word width, reset PC and step.
package fetch_queue_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int DEC_WORD_W = 32;

  localparam logic [PC_WIDTH-1:0] RESET_PC_VAL = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] PC_STEP_VAL  = 32'h0000_0004;

endpackage

// File: rtl/fetch_ring_buffer.sv
// Power-of-two ring buffer holding {word, pc} entries for the fetch queue.
// Clear wins over push/pop; occupancy is tracked explicitly so full and empty
// are unambiguous without a spare slot.
module fetch_ring_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CW-1:0]     occ_q;

  // Storage write at the tail; the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rdata = mem[head];
  assign occ   = occ_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues one imem read per cycle while the queue
// plus the in-flight read has room, and buffers decoded words with their PCs.
// A redirect flushes everything, including the read still in flight.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = PC_WIDTH,
  parameter int              WORD_W   = DEC_WORD_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_VAL),
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(PC_STEP_VAL)
) (
  input  logic                     clk,
  input  logic                     nrst,
  output logic [PC_W-1:0]          imem_addr,
  output logic                     imem_req,
  input  logic [WORD_W-1:0]        dec_word,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_word,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        pend_pc;
  logic                   pend;
  logic [CW-1:0]          occ;
  logic [CW:0]            committed;
  logic                   push;
  logic                   pop;
  logic [WORD_W+PC_W-1:0] head_data;

  // A same-cycle pop is deliberately not credited, so occ + pend never exceeds DEPTH.
  assign committed = {1'b0, occ} + {{CW{1'b0}}, pend};
  assign imem_req  = !redirect && (committed < (CW+1)'(DEPTH));
  assign out_valid = (occ != '0) && !redirect;
  assign push      = pend && !redirect;
  assign pop       = out_valid && out_ready;

  // PC and in-flight tracking; redirect overrides any fetch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= RESET_PC;
    end else if (redirect) begin
      pc      <= redirect_pc;
      pend    <= 1'b0;
    end else if (imem_req) begin
      pc      <= pc + PC_STEP;
      pend    <= 1'b1;
      pend_pc <= pc;
    end else begin
      pend    <= 1'b0;
    end
  end

  fetch_ring_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (WORD_W + PC_W)
  ) u_ring (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({dec_word, pend_pc}),
    .rdata (head_data),
    .occ   (occ)
  );

  assign imem_addr = pc;
  assign out_word  = head_data[WORD_W+PC_W-1:PC_W];
  assign out_pc    = head_data[PC_W-1:0];
  assign count     = occ;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run against a queue-based reference model of the fetch rules.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] dec_word;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .dec_word    (dec_word),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_pc      (out_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Synchronous instruction memory + decoder: word for last cycle's address.
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] garbage;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= imem_req;
      rd_addr  <= imem_addr;
    end
  end
  assign dec_word = rd_valid ? word_of(rd_addr) : garbage;

  // Reference model: fetch PC, one in-flight read, queue of buffered PCs.
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  logic [31:0] mq[$];

  function automatic bit m_req();
    return !redirect && ((mq.size() + int'(m_pend)) < DEPTH);
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0; mq.delete();
  endtask

  task automatic drive(input bit r, input logic [31:0] rpc, input bit rdy);
    redirect = r; redirect_pc = rpc; out_ready = rdy; garbage = $urandom;
    #1;
  endtask

  task automatic tick();
    bit req, pop;
    @(posedge clk);
    req = m_req();
    pop = !redirect && mq.size() != 0 && out_ready;
    if (redirect) begin
      mq.delete(); m_pend = 1'b0; m_pc = redirect_pc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pend_pc);
      if (req) begin
        m_pend_pc = m_pc; m_pc = m_pc + 32'd4; m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    m_reset();
  endtask

  // Occupancy can never exceed DEPTH.
  always @(negedge clk) begin
    if (nrst) begin
      total++;
      if (int'(count) > DEPTH) begin
        bad++; $display("FAIL overflow: count=%0d max=%0d", count, DEPTH);
      end
    end
  end

  task automatic test_reset();
    nrst = 1'b0;
    drive(0, 0, 1);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req: got %b want 1", imem_req); end
    @(negedge clk);
    nrst = 1'b1;
    m_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 1);
      total += 2;
      if (out_valid !== (k >= 2)) begin bad++; $display("FAIL stream_valid k=%0d: got %b want %b", k, out_valid, k >= 2); end
      if (count > 3'd2) begin bad++; $display("FAIL stream_count k=%0d: got %0d want <=2", k, count); end
      if (k >= 2) begin
        total += 2;
        if (out_pc !== 32'((k - 2) * 4)) begin bad++; $display("FAIL stream_pc k=%0d: got %h want %h", k, out_pc, 32'((k - 2) * 4)); end
        if (out_word !== word_of(32'((k - 2) * 4))) begin bad++; $display("FAIL stream_word k=%0d: got %h want %h", k, out_word, word_of(32'((k - 2) * 4))); end
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic [31:0] exp;
    int last_k;
    do_reset();
    repeat (6) begin drive(0, 0, 0); tick(); end
    drive(0, 0, 0);
    total += 4;
    if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", count); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL full_req: got %b want 0", imem_req); end
    if (imem_addr !== 32'd16) begin bad++; $display("FAIL full_addr: got %h want 10", imem_addr); end
    if (out_pc !== 32'd0) begin bad++; $display("FAIL full_head: got %h want 0", out_pc); end
    exp = 0; last_k = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 1);
      if (out_valid) begin
        total++;
        if (out_pc !== exp) begin bad++; $display("FAIL full_drain k=%0d: got %h want %h", k, out_pc, exp); end
        if (exp == 32'd16) begin
          total++;
          if (k - last_k > 2) begin bad++; $display("FAIL full_gap: got %0d cycles want <=2", k - last_k); end
        end
        last_k = k; exp = exp + 4;
      end
      tick();
    end
    total++;
    if (exp < 32'd20) begin bad++; $display("FAIL full_pops: got next %h want >=14", exp); end
  endtask

  task automatic test_redirect_full();
    logic [31:0] exp;
    do_reset();
    repeat (6) begin drive(0, 0, 0); tick(); end
    drive(1, 32'h100, 1);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rdf_valid: got %b want 0", out_valid); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL rdf_req: got %b want 0", imem_req); end
    tick();
    drive(0, 0, 1);
    total += 3;
    if (count !== 3'd0) begin bad++; $display("FAIL rdf_count: got %0d want 0", count); end
    if (imem_addr !== 32'h100) begin bad++; $display("FAIL rdf_addr: got %h want 100", imem_addr); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rdf_valid1: got %b want 0", out_valid); end
    tick();
    drive(0, 0, 1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rdf_valid2: got %b want 0", out_valid); end
    tick();
    exp = 32'h100;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1);
      if (k == 0) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rdf_first: got %b want 1", out_valid); end
      end
      if (out_valid) begin
        total++;
        if (out_pc !== exp) begin bad++; $display("FAIL rdf_seq k=%0d: got %h want %h", k, out_pc, exp); end
        exp = exp + 4;
      end
      tick();
    end
  endtask

  task automatic test_redirect_pend();
    logic [31:0] exp;
    do_reset();
    repeat (4) begin drive(0, 0, 1); tick(); end
    drive(1, 32'h200, 1);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rdp_valid: got %b want 0", out_valid); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL rdp_req: got %b want 0", imem_req); end
    tick();
    drive(0, 0, 1);
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL rdp_count: got %0d want 0", count); end
    tick();
    exp = 32'h200;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1);
      if (out_valid) begin
        total += 2;
        if (out_pc !== exp) begin bad++; $display("FAIL rdp_seq k=%0d: got %h want %h", k, out_pc, exp); end
        if (out_word !== word_of(exp)) begin bad++; $display("FAIL rdp_word k=%0d: got %h want %h", k, out_word, word_of(exp)); end
        exp = exp + 4;
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    bit found;
    for (int rep = 0; rep < 3; rep++) begin
      repeat (rep + 3) begin drive(0, 0, 1); tick(); end
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
        if (mq.size() == 3 && m_pend) found = 1;
        else begin drive(0, 0, mq.size() == DEPTH); tick(); end
      end
      total++;
      if (!found) begin bad++; $display("FAIL wrap_setup rep=%0d: occ=3 with fetch in flight not reached", rep); end
      drive(0, 0, 1);
      total += 2;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid rep=%0d: got %b want 1", rep, out_valid); end
      if (out_pc !== mq[0]) begin bad++; $display("FAIL wrap_pc0 rep=%0d: got %h want %h", rep, out_pc, mq[0]); end
      tick();
      drive(0, 0, 1);
      total += 2;
      if (count !== 3'd3) begin bad++; $display("FAIL wrap_count rep=%0d: got %0d want 3", rep, count); end
      if (out_pc !== mq[0]) begin bad++; $display("FAIL wrap_pc1 rep=%0d: got %h want %h", rep, out_pc, mq[0]); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) begin drive(0, 0, 0); tick(); end
    drive(0, 0, 0);
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL ar_pre: got %0d want 3", count); end
    #2 nrst = 1'b0;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    if (count !== 3'd0) begin bad++; $display("FAIL ar_count: got %0d want 0", count); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL ar_addr: got %h want 0", imem_addr); end
    if (imem_req !== 1'b1) begin bad++; $display("FAIL ar_req: got %b want 1", imem_req); end
    @(negedge clk);
    nrst = 1'b1;
    m_reset();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1);
      total++;
      if (out_valid !== (k >= 2)) begin bad++; $display("FAIL ar_valid k=%0d: got %b want %b", k, out_valid, k >= 2); end
      if (k >= 2) begin
        total++;
        if (out_pc !== 32'((k - 2) * 4)) begin bad++; $display("FAIL ar_pc k=%0d: got %h want %h", k, out_pc, 32'((k - 2) * 4)); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit r, evalid;
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {$urandom_range(0, 32'h3FFF), 2'b00};
      drive(r, rpc, $urandom_range(0, 3) != 0);
      evalid = !r && mq.size() != 0;
      total += 4;
      if (imem_req !== m_req()) begin bad++; $display("FAIL rnd_req k=%0d: got %b want %b", k, imem_req, m_req()); end
      if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr k=%0d: got %h want %h", k, imem_addr, m_pc); end
      if (out_valid !== evalid) begin bad++; $display("FAIL rnd_valid k=%0d: got %b want %b", k, out_valid, evalid); end
      if (int'(count) != mq.size()) begin bad++; $display("FAIL rnd_count k=%0d: got %0d want %0d", k, count, mq.size()); end
      if (evalid) begin
        total += 2;
        if (out_pc !== mq[0]) begin bad++; $display("FAIL rnd_pc k=%0d: got %h want %h", k, out_pc, mq[0]); end
        if (out_word !== word_of(mq[0])) begin bad++; $display("FAIL rnd_word k=%0d: got %h want %h", k, out_word, word_of(mq[0])); end
      end
      tick();
    end
  endtask

  initial begin
    redirect = 0; redirect_pc = 0; out_ready = 0; garbage = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_full();
    test_redirect_pend();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
